// File: rtl/param_datapath_pkg.sv
// Shared constants for param_datapath: opcodes, controller states and
// the instruction-width derivations used by the RTL and its bench.
package param_datapath_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd15;

  // HALTED is not a fifth encoding: it is the halted_q flag freezing the FSM.
  typedef enum logic [1:0] {
    ST_FETCH     = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_e;

  function automatic int calc_ra_w(input int reg_depth);
    return $clog2(reg_depth);
  endfunction

  // op[3:0], isel, rd, rs1, field
  function automatic int calc_instr_w(input int reg_depth, input int imm_w);
    return 4 + 1 + 2 * $clog2(reg_depth) + imm_w;
  endfunction

endpackage

// File: rtl/param_regfile.sv
// Register file: two combinational read ports, a debug read port, one
// synchronous write port, r0 hardwired to zero, synchronous clear.
module param_regfile
  import param_datapath_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int REG_DEPTH = 16,
  localparam int RA_W     = calc_ra_w(REG_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [RA_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [RA_W-1:0]   raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic [RA_W-1:0]   raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic [RA_W-1:0]   dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [REG_DEPTH];

  // Clear on reset; writes to r0 are dropped so it never leaves zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o   = (raddr1_i   == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o   = (raddr2_i   == '0) ? '0 : regs_q[raddr2_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/param_datapath.sv
// Multi-cycle datapath: FETCH/DECODE/EXECUTE/WRITEBACK controller, register
// file, immediate sign-extension and inline ALU, with HALT and retire count.
// Handshake: a word transfers on the rising edge where instr_valid &&
// instr_ready; instr_ready is high only in FETCH while not halted, and the
// word is held in ir_q until the next transfer.
module param_datapath
  import param_datapath_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int REG_DEPTH = 16,
  parameter int IMM_W     = 8,
  parameter int CNT_W     = 16,
  localparam int RA_W     = calc_ra_w(REG_DEPTH),
  localparam int INSTR_W  = calc_instr_w(REG_DEPTH, IMM_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [RA_W-1:0]    dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               halted,
  output logic [CNT_W-1:0]   retired,
  output logic [1:0]         dbg_state
);

  localparam int SH_W = $clog2(DATA_W);

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic                zn_q, zn_d, cn_q, cn_d;
  logic                zero_q, zero_d, carry_q, carry_d;
  logic                halted_q, halted_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  logic [3:0]          op;
  logic                isel;
  logic [RA_W-1:0]     rd, rs1;
  logic [IMM_W-1:0]    field;
  logic [DATA_W-1:0]   imm_sext, rdata1, rdata2;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;
  logic [DATA_W:0]     sum;
  logic                rf_we;

  assign op       = ir_q[INSTR_W-1 -: 4];
  assign isel     = ir_q[INSTR_W-5];
  assign rd       = ir_q[INSTR_W-6 -: RA_W];
  assign rs1      = ir_q[INSTR_W-6-RA_W -: RA_W];
  assign field    = ir_q[IMM_W-1:0];
  assign imm_sext = DATA_W'($signed(field));

  param_regfile #(.DATA_W(DATA_W), .REG_DEPTH(REG_DEPTH)) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .we_i       (rf_we),
    .waddr_i    (rd),
    .wdata_i    (res_q),
    .raddr1_i   (rs1),
    .rdata1_o   (rdata1),
    .raddr2_i   (field[RA_W-1:0]),
    .rdata2_o   (rdata2),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // ALU on the operands latched in DECODE; NOP/HALT codes produce nothing.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    sum       = '0;
    case (op)
      OP_ADD: begin
        sum       = {1'b0, a_q} + {1'b0, b_q};
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
      OP_SUB: begin
        sum       = {1'b0, a_q} - {1'b0, b_q};
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLL:  alu_res = a_q << b_q[SH_W-1:0];
      OP_SRL:  alu_res = a_q >> b_q[SH_W-1:0];
      OP_MOV:  alu_res = b_q;
      default: ;
    endcase
  end

  // Controller next-state and datapath register updates; frozen once halted.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    zn_d        = zn_q;
    cn_d        = cn_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    halted_d    = halted_q;
    retired_d   = retired_q;
    rf_we       = 1'b0;
    instr_ready = 1'b0;
    if (!halted_q) begin
      case (state_q)
        ST_FETCH: begin
          instr_ready = 1'b1;
          if (instr_valid) begin
            ir_d    = instr;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          a_d     = rdata1;
          b_d     = isel ? imm_sext : rdata2;
          state_d = ST_EXECUTE;
        end
        ST_EXECUTE: begin
          if (op == OP_HALT) begin
            halted_d  = 1'b1;
            retired_d = retired_q + CNT_W'(1);
            state_d   = ST_FETCH;
          end else begin
            res_d   = alu_res;
            zn_d    = (alu_res == '0);
            cn_d    = alu_carry;
            state_d = ST_WRITEBACK;
          end
        end
        ST_WRITEBACK: begin
          if (!op[3]) begin
            rf_we   = 1'b1;
            zero_d  = zn_q;
            carry_d = cn_q;
          end
          retired_d = retired_q + CNT_W'(1);
          state_d   = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // State registers with synchronous reset aborting any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      zn_q      <= 1'b0;
      cn_q      <= 1'b0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      zn_q      <= zn_d;
      cn_q      <= cn_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
  assign halted     = halted_q;
  assign retired    = retired_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_param_datapath.sv
// Directed bench for param_datapath with hand-computed expected values.
module tb_param_datapath;
  import param_datapath_pkg::*;

  localparam int DATA_W    = 16;
  localparam int REG_DEPTH = 16;
  localparam int IMM_W     = 8;
  localparam int CNT_W     = 4;
  localparam int RA_W      = calc_ra_w(REG_DEPTH);
  localparam int INSTR_W   = calc_instr_w(REG_DEPTH, IMM_W);

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [INSTR_W-1:0] instr = '0;
  logic               instr_valid = 1'b0;
  logic               instr_ready;
  logic [RA_W-1:0]    dbg_addr = '0;
  logic [DATA_W-1:0]  dbg_data;
  logic               zero_flag, carry_flag, halted;
  logic [CNT_W-1:0]   retired;
  logic [1:0]         dbg_state;

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0]  exp_ret;
  logic [DATA_W-1:0] rv;

  param_datapath #(.DATA_W(DATA_W), .REG_DEPTH(REG_DEPTH), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .halted(halted),
    .retired(retired), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [INSTR_W-1:0] enc(input logic [3:0] op, input logic isel,
      input logic [RA_W-1:0] rd, input logic [RA_W-1:0] rs1, input logic [IMM_W-1:0] fld);
    return {op, isel, rd, rs1, fld};
  endfunction

  task automatic read_reg(input int a, output logic [DATA_W-1:0] v);
    dbg_addr = RA_W'(a);
    #1;
    v = dbg_data;
  endtask

  // Present a word and return 1ns after its acceptance edge.
  task automatic send(input logic [INSTR_W-1:0] w);
    int n;
    n = 0;
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL send_timeout: instr_ready=%0b required 1", instr_ready);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic run(input logic [INSTR_W-1:0] w);
    send(w);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    instr_valid = 1'b1;
    instr = enc(OP_MOV, 1'b1, 4'd5, 4'd0, 8'h44);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", instr_ready); end
    checks++; if (retired !== '0) begin errors++; $display("FAIL rst_retired: got %0d want 0", retired); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
    checks++; if ({zero_flag, carry_flag} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b%b want 00", zero_flag, carry_flag); end
    checks++; if (dbg_state !== ST_FETCH) begin errors++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    for (int i = 0; i < REG_DEPTH; i++) begin
      read_reg(i, rv);
      checks++; if (rv !== '0) begin errors++; $display("FAIL rst_reg%0d: got %h want 0", i, rv); end
    end
    @(negedge clk);
    instr_valid = 1'b0;
    reset = 1'b0;
    exp_ret = '0;
  endtask

  task automatic test_imm_load;
    send(enc(OP_MOV, 1'b1, 4'd5, 4'd0, 8'd20));
    repeat (2) @(posedge clk);
    #1;
    read_reg(5, rv);
    checks++; if (rv !== 16'd0) begin errors++; $display("FAIL mov_early: r5 got %h want 0", rv); end
    checks++; if (dbg_state !== ST_WRITEBACK) begin errors++; $display("FAIL mov_state: got %0d want 3", dbg_state); end
    @(posedge clk); #1;
    exp_ret++;
    read_reg(5, rv);
    checks++; if (rv !== 16'd20) begin errors++; $display("FAIL mov_r5: got %h want 0014", rv); end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL mov_ready: got %b want 1", instr_ready); end
    run(enc(OP_ADD, 1'b1, 4'd8, 4'd5, 8'hFE));
    exp_ret++;
    read_reg(8, rv);
    checks++; if (rv !== 16'd18) begin errors++; $display("FAIL add_r8: got %h want 0012", rv); end
    checks++; if ({zero_flag, carry_flag} !== 2'b01) begin errors++; $display("FAIL add_flags: got z%b c%b want z0 c1", zero_flag, carry_flag); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL add_retired: got %0d want %0d", retired, exp_ret); end
  endtask

  task automatic test_reg_ops;
    run(enc(OP_SUB, 1'b0, 4'd3, 4'd8, 8'h05));
    exp_ret++;
    read_reg(3, rv);
    checks++; if (rv !== 16'hFFFE) begin errors++; $display("FAIL sub_r3: got %h want fffe", rv); end
    checks++; if ({zero_flag, carry_flag} !== 2'b01) begin errors++; $display("FAIL sub_flags: got z%b c%b want z0 c1", zero_flag, carry_flag); end
    run(enc(OP_XOR, 1'b0, 4'd4, 4'd5, 8'h05));
    exp_ret++;
    read_reg(4, rv);
    checks++; if (rv !== 16'h0000) begin errors++; $display("FAIL xor_r4: got %h want 0000", rv); end
    checks++; if ({zero_flag, carry_flag} !== 2'b10) begin errors++; $display("FAIL xor_flags: got z%b c%b want z1 c0", zero_flag, carry_flag); end
    run(enc(OP_MOV, 1'b1, 4'd0, 4'd0, 8'd7));
    exp_ret++;
    read_reg(0, rv);
    checks++; if (rv !== 16'h0000) begin errors++; $display("FAIL r0_write: got %h want 0000", rv); end
    checks++; if ({zero_flag, carry_flag} !== 2'b00) begin errors++; $display("FAIL r0_flags: got z%b c%b want z0 c0", zero_flag, carry_flag); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL r0_retired: got %0d want %0d", retired, exp_ret); end
    run(enc(OP_ADD, 1'b1, 4'd14, 4'd3, 8'h02));
    exp_ret++;
    read_reg(14, rv);
    checks++; if (rv !== 16'h0000) begin errors++; $display("FAIL addwrap_r14: got %h want 0000", rv); end
    checks++; if ({zero_flag, carry_flag} !== 2'b11) begin errors++; $display("FAIL addwrap_flags: got z%b c%b want z1 c1", zero_flag, carry_flag); end
    run(enc(4'd9, 1'b1, 4'd9, 4'd5, 8'h77));
    exp_ret++;
    read_reg(9, rv);
    checks++; if (rv !== 16'h0000) begin errors++; $display("FAIL nop_r9: got %h want 0000", rv); end
    checks++; if ({zero_flag, carry_flag} !== 2'b11) begin errors++; $display("FAIL nop_flags: got z%b c%b want z1 c1", zero_flag, carry_flag); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL nop_retired: got %0d want %0d", retired, exp_ret); end
  endtask

  task automatic test_stalls;
    instr_valid = 1'b0;
    instr = enc(OP_MOV, 1'b1, 4'd9, 4'd0, 8'h11);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (instr_ready !== 1'b1 || dbg_state !== ST_FETCH) begin errors++; $display("FAIL stall_fetch%0d: ready=%b state=%0d want 1/0", i, instr_ready, dbg_state); end
    end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL stall_retired: got %0d want %0d", retired, exp_ret); end
    send(enc(OP_MOV, 1'b1, 4'd9, 4'd0, 8'h33));
    instr = enc(OP_MOV, 1'b1, 4'd9, 4'd0, 8'h55);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr = enc(OP_ADD, 1'b1, 4'd10, 4'd0, 8'h66);
    @(posedge clk); #1;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", instr_ready); end
    instr_valid = 1'b0;
    instr = enc(OP_MOV, 1'b1, 4'd9, 4'd0, 8'h77);
    @(posedge clk); #1;
    exp_ret++;
    read_reg(9, rv);
    checks++; if (rv !== 16'h0033) begin errors++; $display("FAIL latch_r9: got %h want 0033", rv); end
    read_reg(10, rv);
    checks++; if (rv !== 16'h0000) begin errors++; $display("FAIL latch_r10: got %h want 0000", rv); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL latch_retired: got %0d want %0d", retired, exp_ret); end
  endtask

  task automatic test_back_to_back;
    send(enc(OP_MOV, 1'b1, 4'd13, 4'd0, 8'd1));
    instr = enc(OP_ADD, 1'b1, 4'd13, 4'd13, 8'd1);
    instr_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    read_reg(13, rv);
    checks++; if (rv !== 16'd1) begin errors++; $display("FAIL b2b_first: r13 got %h want 0001", rv); end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", instr_ready); end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_ret = exp_ret + 2;
    read_reg(13, rv);
    checks++; if (rv !== 16'd2) begin errors++; $display("FAIL b2b_second: r13 got %h want 0002", rv); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL b2b_retired: got %0d want %0d", retired, exp_ret); end
  endtask

  task automatic test_halt;
    send(enc(OP_HALT, 1'b0, 4'd0, 4'd0, 8'd0));
    instr_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b want 0", halted); end
    @(posedge clk); #1;
    exp_ret++;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b want 1", halted); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL halt_retired: got %0d want %0d", retired, exp_ret); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL halt_ready: got %b want 0", instr_ready); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL halt_once: got %0d want %0d", retired, exp_ret); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    instr_valid = 1'b0;
    exp_ret = '0;
    checks++; if (halted !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL halt_reset: halted=%b ready=%b want 0/1", halted, instr_ready); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL halt_reset_ret: got %0d want 0", retired); end
  endtask

  task automatic test_reset_mid;
    send(enc(OP_MOV, 1'b1, 4'd6, 4'd0, 8'd9));
    @(posedge clk); #1;
    checks++; if (dbg_state !== ST_EXECUTE) begin errors++; $display("FAIL mid_state: got %0d want 2", dbg_state); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (dbg_state !== ST_FETCH || instr_ready !== 1'b1) begin errors++; $display("FAIL mid_fetch: state=%0d ready=%b want 0/1", dbg_state, instr_ready); end
    repeat (3) @(posedge clk);
    #1;
    read_reg(6, rv);
    checks++; if (rv !== 16'd0) begin errors++; $display("FAIL mid_r6: got %h want 0000", rv); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL mid_retired: got %0d want 0", retired); end
  endtask

  task automatic test_shift;
    run(enc(OP_MOV, 1'b1, 4'd5, 4'd0, 8'd20));
    run(enc(OP_SLL, 1'b1, 4'd10, 4'd5, 8'd3));
    read_reg(10, rv);
    checks++; if (rv !== 16'd160) begin errors++; $display("FAIL sll_r10: got %h want 00a0", rv); end
    run(enc(OP_MOV, 1'b1, 4'd11, 4'd0, 8'd1));
    run(enc(OP_SLL, 1'b1, 4'd11, 4'd11, 8'd15));
    read_reg(11, rv);
    checks++; if (rv !== 16'h8000) begin errors++; $display("FAIL sll_r11: got %h want 8000", rv); end
    run(enc(OP_SRL, 1'b1, 4'd12, 4'd11, 8'd15));
    exp_ret = exp_ret + 5;
    read_reg(12, rv);
    checks++; if (rv !== 16'd1) begin errors++; $display("FAIL srl_r12: got %h want 0001", rv); end
    checks++; if ({zero_flag, carry_flag} !== 2'b00) begin errors++; $display("FAIL srl_flags: got z%b c%b want z0 c0", zero_flag, carry_flag); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL shift_retired: got %0d want %0d", retired, exp_ret); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 10; i++) begin
      run(enc(4'd8, 1'b0, 4'd1, 4'd1, 8'd0));
      exp_ret++;
    end
    checks++; if (retired !== 4'd15) begin errors++; $display("FAIL wrap_max: got %0d want 15", retired); end
    run(enc(4'd14, 1'b0, 4'd1, 4'd1, 8'd0));
    checks++; if (retired !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", retired); end
  endtask

  initial begin
    test_reset();
    test_imm_load();
    test_reg_ops();
    test_stalls();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    test_shift();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
